pipe_stage_skid: RTL and testbench

Parametrised elastic pipeline-stage register, the successor to the fixed-field stage latches between EX/MEM and MEM/WB. It carries a generic control bundle and data bundle with a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered `in_ready`. A synchronous flush inserts bubbles, and a saturating counter records downstream back-pressure cycles. Instances sit between any two pipeline stages of the RV32 core.

---
 rtl/pipe_stage_skid.sv | 102 ++++++++++
 tb/tb_pipe_stage_skid.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline stage with 2-entry skid buffer, flush and stall counter
module pipe_stage_skid #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Main entry M drives the outputs; skid entry S catches one beat while M is blocked.
   logic              m_valid;
   logic [CTRL_W-1:0] m_ctrl;
   logic [DATA_W-1:0] m_data;
   logic              s_valid;
   logic [CTRL_W-1:0] s_ctrl;
   logic [DATA_W-1:0] s_data;

   logic accept;
   logic drain;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // in_ready is the inverse of a flop, so there is no path from out_ready to it.
   assign in_ready  = ~s_valid;
   assign out_valid = m_valid;
   assign out_ctrl  = m_valid ? m_ctrl : '0;
   assign out_data  = m_data;

   assign accept = in_valid & in_ready;
   assign drain  = m_valid & out_ready;

   // Occupancy control: EMPTY (M and S free), ONE (M only), FULL (M and S); flush empties the stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_ctrl  <= '0;
         m_data  <= '0;
         s_valid <= 1'b0;
         s_ctrl  <= '0;
         s_data  <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
         m_ctrl  <= '0;
         s_valid <= 1'b0;
         s_ctrl  <= '0;
      end else begin
         case ({m_valid, s_valid})
            2'b00: begin
               if (accept) begin
                  m_valid <= 1'b1;
                  m_ctrl  <= in_ctrl;
                  m_data  <= in_data;
               end
            end
            2'b10: begin
               if (accept && drain) begin
                  m_ctrl <= in_ctrl;
                  m_data <= in_data;
               end else if (accept) begin
                  s_valid <= 1'b1;
                  s_ctrl  <= in_ctrl;
                  s_data  <= in_data;
               end else if (drain) begin
                  m_valid <= 1'b0;
               end
            end
            2'b11: begin
               if (drain) begin
                  m_ctrl  <= s_ctrl;
                  m_data  <= s_data;
                  s_valid <= 1'b0;
               end
            end
            default: begin
               // S without M cannot arise; recover to EMPTY.
               s_valid <= 1'b0;
            end
         endcase
      end
   end

   // Saturating count of cycles where a presented beat is back-pressured; only reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (m_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid with a queue-based model
module tb_pipe_stage_skid;

   localparam int DW = 16;
   localparam int CW = 8;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_ctrl = '0;
   logic [DW-1:0] in_data = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [NW-1:0] stall_cnt;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
   } beat_t;

   beat_t         mq[$];
   logic [DW-1:0] m_last = '0;
   int            m_cnt = 0;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_data(out_data), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a FIFO of at most two beats; the head is what is presented downstream.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_last = '0;
         m_cnt = 0;
      end else begin
         bit acc;
         bit drn;
         acc = in_valid && (mq.size() < 2);
         drn = (mq.size() > 0) && out_ready;
         if (mq.size() > 0) m_last = mq[0].data;
         if ((mq.size() > 0) && !out_ready && (m_cnt < 15)) m_cnt++;
         if (flush) begin
            mq.delete();
         end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back({in_ctrl, in_data});
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         check("m_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
         check("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
         check("m_out_ctrl", {24'd0, out_ctrl}, (mq.size() > 0) ? {24'd0, mq[0].ctrl} : 32'd0);
         check("m_out_data", {16'd0, out_data}, (mq.size() > 0) ? {16'd0, mq[0].data} : {16'd0, m_last});
         check("m_stall_cnt", {28'd0, stall_cnt}, m_cnt);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d, input bit r);
      in_valid = v;
      in_ctrl = c;
      in_data = d;
      out_ready = r;
   endtask

   task automatic sync_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      drive(0, 0, 0, 0);
      step();
      step();
      rst = 1'b0;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_ctrl", {24'd0, out_ctrl}, 32'd0);
      check("rst_out_data", {16'd0, out_data}, 32'd0);
      check("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
      cmp_en = 1'b1;

      // Streaming at full rate
      for (int i = 1; i <= 10; i++) begin
         drive(1, CW'(i), DW'(i), 1);
         step();
         if (i == 1) begin
            check("stream_first_ctrl", {24'd0, out_ctrl}, 32'h01);
            check("stream_first_data", {16'd0, out_data}, 32'd1);
         end
         check("stream_ready", {31'd0, in_ready}, 32'd1);
      end
      check("stream_last_ctrl", {24'd0, out_ctrl}, 32'h0A);
      drive(0, 0, 0, 1);
      step();
      check("stream_stall", {28'd0, stall_cnt}, 32'd0);

      // Skid: A, B, C back-to-back with out_ready low once A is presented
      drive(1, 8'hA1, 16'h00A1, 1);
      step();
      drive(1, 8'hB2, 16'h00B2, 0);
      step();
      drive(1, 8'hC3, 16'h00C3, 0);
      step();
      check("skid_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("skid_holds_A", {24'd0, out_ctrl}, 32'hA1);
      step();
      step();
      drive(1, 8'hC3, 16'h00C3, 1);
      step();
      check("skid_B_next", {24'd0, out_ctrl}, 32'hB2);
      step();
      check("skid_C_next", {24'd0, out_ctrl}, 32'hC3);
      drive(0, 0, 0, 1);
      step();
      check("skid_empty", {31'd0, out_valid}, 32'd0);

      // Flush while FULL with a live input beat
      drive(1, 8'hD4, 16'h0D04, 0);
      step();
      drive(1, 8'hE5, 16'h0E05, 0);
      step();
      drive(1, 8'hF6, 16'h0F06, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_ctrl", {24'd0, out_ctrl}, 32'd0);
      check("flush_data_held", {16'd0, out_data}, 32'h0D04);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      drive(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step();
      check("flush_no_ghost", {31'd0, out_valid}, 32'd0);

      // Counter saturation at 4 bits
      sync_reset();
      drive(1, 8'h5A, 16'h1111, 0);
      step();
      drive(0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step();
      check("sat_15", {28'd0, stall_cnt}, 32'd15);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("sat_after_flush", {28'd0, stall_cnt}, 32'd15);
      check("sat_flush_valid", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset between edges while FULL
      drive(1, 8'h77, 16'h7777, 0);
      step();
      drive(1, 8'h88, 16'h8888, 0);
      step();
      drive(0, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check("areset_valid", {31'd0, out_valid}, 32'd0);
      check("areset_ctrl", {24'd0, out_ctrl}, 32'd0);
      check("areset_data", {16'd0, out_data}, 32'd0);
      check("areset_ready", {31'd0, in_ready}, 32'd1);
      check("areset_cnt", {28'd0, stall_cnt}, 32'd0);
      #1;
      rst = 1'b0;
      step();

      // Bubble gating of ctrl after the only beat drains
      drive(1, 8'hFF, 16'h1234, 1);
      step();
      check("bubble_presented", {24'd0, out_ctrl}, 32'hFF);
      drive(0, 0, 0, 1);
      step();
      check("bubble_valid", {31'd0, out_valid}, 32'd0);
      check("bubble_ctrl", {24'd0, out_ctrl}, 32'h00);
      check("bubble_data", {16'd0, out_data}, 32'h1234);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
